column_scheduler: RTL and testbench
===================================

Name: column_scheduler

Overview:
- Sequences LED column output for the light painter from decoded encoder motion.
- Consumes one-cycle step pulses with direction from the quadrature decode stage.
- Converts travel into column-boundary events and issues column indices to the LED frame driver over a req/ack handshake.
- Buffers a small number of outstanding columns and suppresses re-painting after backward motion.

Parameters:
- STEPS_PER_COL, 4, encoder steps per painted column (>=2)
- NUM_COLS, 32, columns per image; last index NUM_COLS-1
- COL_W, 5, width of col_index and backlog (2^COL_W >= NUM_COLS)
- MAX_PEND, 3, maximum outstanding column events (>=1)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately
- enable  in  1  arm painting; 0 aborts to IDLE
- step_valid  in  1  one-cycle pulse, one encoder step (already synchronized)
- step_dir  in  1  1 = forward, 0 = backward; valid with step_valid
- col_ack  in  1  frame driver accepted current column
- col_req  out  1  column request, registered
- col_index  out  COL_W  column to paint; stable while col_req=1
- busy  out  1  state != IDLE
- done  out  1  all NUM_COLS columns accepted
- overrun  out  1  sticky: boundary event dropped because pending was full

Behaviour:
- Reset (reset=0, async): state IDLE; col_req=0, col_index=0, busy=0, done=0, overrun=0; step_acc=0, backlog=0, pending=0.
- States:
  - IDLE: all step and ack inputs ignored; col_req=0.
  - IDLE->RUN at the first edge with enable=1. On that edge: step_acc=0, backlog=0, col_index=0, overrun=0, done=0, pending=1. Column 0 is therefore requested immediately; col_req=1 after that edge.
  - RUN->DONE on the edge where col_req&col_ack with col_index=NUM_COLS-1. On that edge: col_req=0, done=1, pending=0.
  - DONE: steps ignored; done held.
  - RUN/DONE->IDLE at any edge with enable=0. col_req drops after that edge even mid-handshake (abort); col_ack ignored in that cycle. done and overrun cleared.
- Step accumulation (RUN only, on step_valid):
  - Forward: if step_acc==STEPS_PER_COL-1, then step_acc=0 and a boundary event occurs; else step_acc+1.
  - Backward: if step_acc==0, then step_acc=STEPS_PER_COL-1 and backlog+1 (saturates at 2^COL_W-1); else step_acc-1.
  - Forward boundary with backlog>0: backlog-1, no column event (re-traversed ground is not repainted).
  - Forward boundary with backlog==0: column event.
- Pending / handshake:
  - Column event with pending<MAX_PEND: pending+1.
  - Column event with pending==MAX_PEND: event dropped, overrun=1 (sticky until next arm).
  - Transfer = col_req&col_ack at an edge: pending-1, col_index+1.
  - Column event and transfer on the same edge: pending unchanged, col_index+1, no overrun even if pending==MAX_PEND.
  - col_req is registered and equals (state==RUN && pending_next>0).
  - Latency: step_valid at edge N producing a column event with pending=0 gives col_req=1 after edge N.
  - Back-to-back: after a transfer with pending still >0, col_req stays high and col_index advances by exactly 1 per transfer.
  - col_ack while col_req=0: ignored.
- Width rules:
  - pending width = clog2(MAX_PEND+1).
  - step_acc width = clog2(STEPS_PER_COL).
  - col_index never exceeds NUM_COLS-1 and never wraps; DONE is entered first.
- Reset mid-operation: asynchronous clear to reset values regardless of state or handshake phase.

Test Plan:
- Reset 0 during RUN with col_req=1 -> all outputs 0 immediately without waiting for clk; after release with enable=1, col_req=1, col_index=0 one edge later.
- Arm, ack col 0, then 8 forward steps with col_ack tied 1 (STEPS_PER_COL=4) -> col_index 1 then 2, each col_req pulse 1 cycle after the 4th/8th step; pending returns to 0.
- After col 0 acked: 4 forward, 4 backward, 8 forward, ack always 1 -> col 1 issued once; backward sets backlog=1; next 4 forward give no request; following 4 forward issue col 2.
- col_ack held 0, 20 forward steps (MAX_PEND=3; col 0 already pending) -> pending saturates at 3; col 1 and 2 events accepted, 3rd dropped sets overrun=1 and stays 1; then 3 acks -> indices 0,1,2, col_req low.
- NUM_COLS=4, continuous forward steps and ack -> indices 0..3, done=1 on col 3 transfer, further steps produce no col_req; enable=0 -> IDLE, done=0, busy=0.
- Boundary event on same edge as transfer with pending=MAX_PEND -> no overrun, col_index+1, pending unchanged; enable=0 mid-request -> col_req 0 next cycle, ack that cycle ignored.

Source files
------------

// File: rtl/column_scheduler.sv
// rtl/column_scheduler.sv - turns encoder step pulses into LED column requests
// for the light painter, with a bounded backlog of outstanding columns.
module column_scheduler #(
  parameter int STEPS_PER_COL = 4,
  parameter int NUM_COLS      = 32,
  parameter int COL_W         = 5,
  parameter int MAX_PEND      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             step_valid,
  input  logic             step_dir,
  input  logic             col_ack,
  output logic             col_req,
  output logic [COL_W-1:0] col_index,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam int PW = $clog2(MAX_PEND + 1);
  localparam int SW = $clog2(STEPS_PER_COL);
  localparam logic [SW-1:0]    ACC_MAX  = SW'(STEPS_PER_COL - 1);
  localparam logic [PW-1:0]    PEND_MAX = PW'(MAX_PEND);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
  localparam logic [COL_W-1:0] BL_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    step_acc_q, step_acc_d;
  logic [COL_W-1:0] backlog_q, backlog_d;
  logic [PW-1:0]    pending_q, pending_d;
  logic [COL_W-1:0] col_index_q, col_index_d;
  logic             col_req_q, col_req_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;
  logic             transfer;
  logic             last_transfer;
  logic             col_event;

  assign transfer      = col_req_q & col_ack;
  assign last_transfer = transfer && (col_index_q == LAST_COL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      step_acc_q  <= '0;
      backlog_q   <= '0;
      pending_q   <= '0;
      col_index_q <= '0;
      col_req_q   <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_acc_q  <= step_acc_d;
      backlog_q   <= backlog_d;
      pending_q   <= pending_d;
      col_index_q <= col_index_d;
      col_req_q   <= col_req_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable) state_d = S_RUN;
      S_RUN: begin
        if (!enable)            state_d = S_IDLE;
        else if (last_transfer) state_d = S_DONE;
      end
      S_DONE:  if (!enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    step_acc_d  = step_acc_q;
    backlog_d   = backlog_q;
    pending_d   = pending_q;
    col_index_d = col_index_q;
    done_d      = done_q;
    overrun_d   = overrun_q;
    col_event   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          step_acc_d  = '0;
          backlog_d   = '0;
          col_index_d = '0;
          overrun_d   = 1'b0;
          done_d      = 1'b0;
          pending_d   = PW'(1);
        end
      end
      S_RUN: begin
        if (!enable) begin
          pending_d = '0;
          done_d    = 1'b0;
          overrun_d = 1'b0;
        end else begin
          if (step_valid) begin
            if (step_dir) begin
              if (step_acc_q == ACC_MAX) begin
                step_acc_d = '0;
                // Ground already painted once is skipped until the backlog drains.
                if (backlog_q != '0) backlog_d = backlog_q - 1'b1;
                else                 col_event = 1'b1;
              end else begin
                step_acc_d = step_acc_q + 1'b1;
              end
            end else begin
              if (step_acc_q == '0) begin
                step_acc_d = ACC_MAX;
                if (backlog_q != BL_MAX) backlog_d = backlog_q + 1'b1;
              end else begin
                step_acc_d = step_acc_q - 1'b1;
              end
            end
          end
          if (last_transfer) begin
            pending_d = '0;
            done_d    = 1'b1;
          end else begin
            if (transfer) col_index_d = col_index_q + 1'b1;
            if (col_event && !transfer) begin
              if (pending_q == PEND_MAX) overrun_d = 1'b1;
              else                       pending_d = pending_q + 1'b1;
            end else if (!col_event && transfer) begin
              pending_d = pending_q - 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        if (!enable) begin
          done_d    = 1'b0;
          overrun_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    col_req_d = (state_d == S_RUN) && (pending_d != '0);
    col_req   = col_req_q;
    col_index = col_index_q;
    busy      = (state_q != S_IDLE);
    done      = done_q;
    overrun   = overrun_q;
  end

endmodule

// File: tb/tb_column_scheduler.sv
// tb/tb_column_scheduler.sv - self-checking bench for column_scheduler with a
// scoreboard of expected column indices compared at each handshake.
module tb_column_scheduler;
  localparam int SPC = 4;
  localparam int NC  = 4;
  localparam int CW  = 5;
  localparam int MP  = 3;

  logic          clk = 1'b0;
  logic          reset, enable, step_valid, step_dir, col_ack;
  logic          col_req, busy, done, overrun;
  logic [CW-1:0] col_index;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int sb_exp;

  always #5 clk = ~clk;

  column_scheduler #(.STEPS_PER_COL(SPC), .NUM_COLS(NC), .COL_W(CW), .MAX_PEND(MP)) dut (
    .clk(clk), .reset(reset), .enable(enable), .step_valid(step_valid),
    .step_dir(step_dir), .col_ack(col_ack), .col_req(col_req),
    .col_index(col_index), .busy(busy), .done(done), .overrun(overrun)
  );

  // A handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (reset === 1'b1 && enable === 1'b1 && col_req === 1'b1 && col_ack === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got col_index=%0d, required no transfer", col_index);
      end else begin
        sb_exp = exp_q.pop_front();
        if (col_index !== CW'(sb_exp)) begin
          fails++;
          $display("FAIL sb_col_index: got %0d, required %0d", col_index, sb_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic step(input logic dir);
    step_valid = 1'b1;
    step_dir   = dir;
    tick();
    step_valid = 1'b0;
  endtask

  task automatic arm();
    enable = 1'b1;
    exp_q.push_back(0);
    tick();
    chk("arm_col_req", 32'(col_req), 1);
    chk("arm_col_index", 32'(col_index), 0);
    chk("arm_busy", 32'(busy), 1);
  endtask

  task automatic disarm(input int leftover);
    enable     = 1'b0;
    col_ack    = 1'b0;
    step_valid = 1'b0;
    tick();
    chk("disarm_col_req", 32'(col_req), 0);
    chk("disarm_busy", 32'(busy), 0);
    chk("disarm_done", 32'(done), 0);
    chk("disarm_overrun", 32'(overrun), 0);
    chk("sb_leftover", 32'(exp_q.size()), 32'(leftover));
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; step_valid = 1'b0; step_dir = 1'b0; col_ack = 1'b0;
    #3;
    chk("rst_col_req", 32'(col_req), 0);
    chk("rst_col_index", 32'(col_index), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_overrun", 32'(overrun), 0);
    reset = 1'b1;
    tick();
    arm();
    exp_q.delete();
    #2 reset = 1'b0;
    #1;
    chk("async_rst_col_req", 32'(col_req), 0);
    chk("async_rst_busy", 32'(busy), 0);
    #2 reset = 1'b1;
    tick();
    chk("rearm_col_req", 32'(col_req), 1);
    chk("rearm_col_index", 32'(col_index), 0);
    disarm(0);
  endtask

  task automatic test_forward();
    arm();
    col_ack = 1'b1;
    tick();
    chk("fwd_col0_done_req", 32'(col_req), 0);
    for (int i = 1; i <= 8; i++) begin
      if (i % 4 == 0) exp_q.push_back(i / 4);
      step(1'b1);
      chk("fwd_col_req", 32'(col_req), (i % 4 == 0) ? 1 : 0);
      if (i % 4 == 0) chk("fwd_col_index", 32'(col_index), 32'(i / 4));
    end
    tick();
    chk("fwd_drain_req", 32'(col_req), 0);
    chk("fwd_drain_index", 32'(col_index), 3);
    disarm(0);
  endtask

  task automatic test_backlog();
    arm();
    col_ack = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) exp_q.push_back(1);
      step(1'b1);
    end
    chk("bl_col1_req", 32'(col_req), 1);
    chk("bl_col1_index", 32'(col_index), 1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0);
      chk("bl_back_req", 32'(col_req), 0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      chk("bl_retrace_req", 32'(col_req), 0);
    end
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) exp_q.push_back(2);
      step(1'b1);
      chk("bl_new_req", 32'(col_req), (i == 4) ? 1 : 0);
    end
    chk("bl_col2_index", 32'(col_index), 2);
    tick();
    chk("bl_drain_req", 32'(col_req), 0);
    disarm(0);
  endtask

  task automatic test_overrun();
    arm();
    col_ack = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 4) exp_q.push_back(1);
      if (i == 8) exp_q.push_back(2);
      step(1'b1);
      if (i == 11) chk("ovr_before_drop", 32'(overrun), 0);
      if (i == 12) chk("ovr_at_drop", 32'(overrun), 1);
    end
    chk("ovr_sticky", 32'(overrun), 1);
    chk("ovr_req_held", 32'(col_req), 1);
    chk("ovr_index_held", 32'(col_index), 0);
    col_ack = 1'b1;
    tick();
    tick();
    chk("ovr_drain2_req", 32'(col_req), 1);
    tick();
    chk("ovr_drain3_req", 32'(col_req), 0);
    chk("ovr_drain3_index", 32'(col_index), 3);
    chk("ovr_drain3_done", 32'(done), 0);
    chk("ovr_after_drain", 32'(overrun), 1);
    disarm(0);
  endtask

  task automatic test_done();
    arm();
    col_ack = 1'b1;
    tick();
    for (int i = 1; i <= 20; i++) begin
      if (i % 4 == 0 && i <= 12) exp_q.push_back(i / 4);
      step(1'b1);
      if (i == 13) begin
        chk("done_flag", 32'(done), 1);
        chk("done_busy", 32'(busy), 1);
      end
      if (i >= 13) chk("done_no_req", 32'(col_req), 0);
    end
    chk("done_held", 32'(done), 1);
    chk("done_index", 32'(col_index), NC - 1);
    disarm(0);
  endtask

  task automatic test_back_to_back();
    arm();
    col_ack = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      if (i == 4) exp_q.push_back(1);
      if (i == 8) exp_q.push_back(2);
      step(1'b1);
    end
    chk("b2b_no_ovr_yet", 32'(overrun), 0);
    col_ack = 1'b1;
    exp_q.push_back(3);
    step(1'b1);
    chk("same_edge_overrun", 32'(overrun), 0);
    chk("same_edge_index", 32'(col_index), 1);
    chk("same_edge_req", 32'(col_req), 1);
    tick();
    tick();
    chk("b2b_req_high", 32'(col_req), 1);
    chk("b2b_index", 32'(col_index), 3);
    tick();
    chk("b2b_req_low", 32'(col_req), 0);
    chk("b2b_done", 32'(done), 1);
    disarm(0);
  endtask

  task automatic test_abort();
    arm();
    enable  = 1'b0;
    col_ack = 1'b1;
    tick();
    chk("abort_req", 32'(col_req), 0);
    chk("abort_busy", 32'(busy), 0);
    col_ack = 1'b0;
    exp_q.delete();
    arm();
    disarm(1);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_backlog();
    test_overrun();
    test_done();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
